// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues one instruction-memory read at a time and buffers
// returned words, each with its fetch address, in a DEPTH-entry FIFO for the decoder.
module instr_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [7:0]        pc_in,
  input  logic              pc_valid_in,
  output logic              pc_ready_out,
  input  logic              flush_in,
  output logic              mem_req_out,
  output logic [7:0]        mem_addr_out,
  input  logic              mem_ack_in,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic [DATA_W-1:0] instr_out,
  output logic [7:0]        instr_addr_out,
  output logic              instr_valid_out,
  input  logic              instr_ready_in,
  output logic [3:0]        count_out
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [3:0]       DEPTH_C = 4'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t            state_r;
  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic [7:0]        addr_mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [3:0]        count_r;
  logic              accept_s;
  logic              push_s;
  logic              pop_s;

  // Flush suppresses new fetches, the ack write and the decoder pop in its own cycle.
  assign pc_ready_out    = (state_r == ST_IDLE) && (count_r < DEPTH_C) && !flush_in;
  assign accept_s        = pc_valid_in && pc_ready_out;
  assign push_s          = (state_r == ST_WAIT) && mem_ack_in && !flush_in;
  assign pop_s           = instr_valid_out && instr_ready_in && !flush_in;
  assign instr_valid_out = (count_r != 4'd0);
  assign count_out       = count_r;
  assign instr_out       = data_mem_r[rd_ptr_r];
  assign instr_addr_out  = addr_mem_r[rd_ptr_r];

  // Read-issue FSM: owns the single outstanding memory request and its address.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r      <= ST_IDLE;
      mem_req_out  <= 1'b0;
      mem_addr_out <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r      <= ST_WAIT;
            mem_req_out  <= 1'b1;
            mem_addr_out <= pc_in;
          end
        end
        ST_WAIT: begin
          if (mem_ack_in) begin
            state_r     <= ST_IDLE;
            mem_req_out <= 1'b0;
          end else if (flush_in) begin
            state_r <= ST_DROP;
          end
        end
        ST_DROP: begin
          if (mem_ack_in) begin
            state_r     <= ST_IDLE;
            mem_req_out <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          mem_req_out <= 1'b0;
        end
      endcase
    end
  end

  // Entry storage: tail write of the returned word tagged with its fetch address.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_r[i] <= {DATA_W{1'b0}};
        addr_mem_r[i] <= 8'h00;
      end
    end else if (push_s) begin
      data_mem_r[wr_ptr_r] <= mem_data_in;
      addr_mem_r[wr_ptr_r] <= mem_addr_out;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= 4'd0;
    end else if (flush_in) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= 4'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 4'd1;
        2'b01:   count_r <= count_r - 4'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Table-driven bench for instr_fetch_queue with a scoreboard of expected {addr, data}
// entries pushed on each modelled ack and compared when the decoder pops.
module tb_instr_fetch_queue;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [7:0]  pc_in;
  logic        pc_valid_in;
  logic        pc_ready_out;
  logic        flush_in;
  logic        mem_req_out;
  logic [7:0]  mem_addr_out;
  logic        mem_ack_in;
  logic [31:0] mem_data_in;
  logic [31:0] instr_out;
  logic [7:0]  instr_addr_out;
  logic        instr_valid_out;
  logic        instr_ready_in;
  logic [3:0]  count_out;

  instr_fetch_queue #(.DEPTH(4), .DATA_W(32)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .pc_in           (pc_in),
    .pc_valid_in     (pc_valid_in),
    .pc_ready_out    (pc_ready_out),
    .flush_in        (flush_in),
    .mem_req_out     (mem_req_out),
    .mem_addr_out    (mem_addr_out),
    .mem_ack_in      (mem_ack_in),
    .mem_data_in     (mem_data_in),
    .instr_out       (instr_out),
    .instr_addr_out  (instr_addr_out),
    .instr_valid_out (instr_valid_out),
    .instr_ready_in  (instr_ready_in),
    .count_out       (count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        pv;
    logic [7:0]  pc;
    logic        ack;
    logic [31:0] d;
    logic        rdy;
    logic        fl;
    logic        e_req;
    logic        e_val;
    logic [3:0]  e_cnt;
    logic        e_prdy;
  } vec_t;

  vec_t        tbl[$];
  logic [39:0] sb[$];
  logic        m_pend = 1'b0;
  logic        m_drop = 1'b0;
  logic [7:0]  m_addr = 8'h00;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic vec_t mk(input logic pv, input logic [7:0] pc, input logic ack,
                              input logic [31:0] d, input logic rdy, input logic fl,
                              input logic e_req, input logic e_val, input logic [3:0] e_cnt,
                              input logic e_prdy);
    vec_t v;
    v.pv = pv; v.pc = pc; v.ack = ack; v.d = d; v.rdy = rdy; v.fl = fl;
    v.e_req = e_req; v.e_val = e_val; v.e_cnt = e_cnt; v.e_prdy = e_prdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus (called just after a negedge), check, then step the model.
  task automatic run_vec(input vec_t v, input bit use_exp);
    logic [39:0] exp_e;
    int sz;
    pc_valid_in = v.pv; pc_in = v.pc; mem_ack_in = v.ack; mem_data_in = v.d;
    instr_ready_in = v.rdy; flush_in = v.fl;
    #1;
    sz = sb.size();
    chk("count_vs_model", 40'(count_out), 40'(sz));
    if (use_exp) begin
      chk("tbl_mem_req", 40'(mem_req_out), 40'(v.e_req));
      chk("tbl_instr_valid", 40'(instr_valid_out), 40'(v.e_val));
      chk("tbl_count", 40'(count_out), 40'(v.e_cnt));
      chk("tbl_pc_ready", 40'(pc_ready_out), 40'(v.e_prdy));
    end
    if (sz != 0 && v.rdy && !v.fl) begin
      exp_e = sb.pop_front();
      chk("pop_addr", 40'(instr_addr_out), 40'(exp_e[39:32]));
      chk("pop_data", 40'(instr_out), 40'(exp_e[31:0]));
    end
    if (m_pend) begin
      if (v.ack) begin
        if (!m_drop && !v.fl) sb.push_back({m_addr, v.d});
        m_pend = 1'b0;
        m_drop = 1'b0;
      end else if (v.fl) begin
        m_drop = 1'b1;
      end
    end else if (v.pv && !v.fl && sz < 4) begin
      m_pend = 1'b1;
      m_addr = v.pc;
    end
    if (v.fl) sb.delete();
    @(negedge clk_in);
  endtask

  initial begin
    rst_n_in = 1'b0; pc_in = 8'h00; pc_valid_in = 1'b0; flush_in = 1'b0;
    mem_ack_in = 1'b0; mem_data_in = 32'h0; instr_ready_in = 1'b0;

    // pv pc ack data rdy fl | req val cnt prdy
    tbl.push_back(mk(1'b1, 8'h10, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 32'hE3A01005, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1));
    // fill to full, refused fetch, then drain in order
    for (int i = 0; i < 4; i++) begin
      tbl.push_back(mk(1'b1, 8'(i), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, (i != 0), 4'(i), 1'b1));
      tbl.push_back(mk(1'b0, 8'h00, 1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b1, (i != 0), 4'(i), 1'b0));
    end
    tbl.push_back(mk(1'b1, 8'h04, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1));
    // flush with a read pending: DROP swallows the late ack
    tbl.push_back(mk(1'b1, 8'h20, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 32'hB0,       1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0));
    tbl.push_back(mk(1'b1, 8'h21, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 32'hB1,       1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0));
    tbl.push_back(mk(1'b1, 8'h05, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 1'b0));
    tbl.push_back(mk(1'b1, 8'h66, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1));
    // flush coincident with ack, then flush in IDLE blocks a fetch
    tbl.push_back(mk(1'b1, 8'h30, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 32'hC0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0));
    tbl.push_back(mk(1'b1, 8'h31, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 32'hC1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 1'b0));
    tbl.push_back(mk(1'b1, 8'h32, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 32'hC2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1));
    tbl.push_back(mk(1'b1, 8'h40, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1));
    // push and pop in the same cycle at count 2
    tbl.push_back(mk(1'b1, 8'h50, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 32'hD0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0));
    tbl.push_back(mk(1'b1, 8'h51, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 32'hD1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0));
    tbl.push_back(mk(1'b1, 8'h52, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 32'hD2, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1));

    repeat (3) @(negedge clk_in);
    chk("rst_mem_req", 40'(mem_req_out), 40'h0);
    chk("rst_mem_addr", 40'(mem_addr_out), 40'h0);
    chk("rst_count", 40'(count_out), 40'h0);
    chk("rst_instr_valid", 40'(instr_valid_out), 40'h0);
    chk("rst_instr_out", 40'(instr_out), 40'h0);
    chk("rst_instr_addr", 40'(instr_addr_out), 40'h0);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    foreach (tbl[i]) run_vec(tbl[i], 1'b1);

    // streaming through more than two laps of the pointers
    for (int i = 0; i < 12; i++) begin
      run_vec(mk(1'b1, 8'h80 + 8'(i), 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0), 1'b0);
      run_vec(mk(1'b0, 8'h00, 1'b1, $urandom, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0), 1'b0);
    end
    run_vec(mk(1'b0, 8'h00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0), 1'b0);
    chk("wrap_drained", 40'(count_out), 40'h0);

    // asynchronous reset in the middle of an outstanding read
    run_vec(mk(1'b1, 8'h60, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0), 1'b0);
    run_vec(mk(1'b0, 8'h00, 1'b1, 32'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0), 1'b0);
    run_vec(mk(1'b1, 8'h61, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0), 1'b0);
    pc_valid_in = 1'b0;
    #1;
    chk("pre_rst_mem_req", 40'(mem_req_out), 40'h1);
    chk("pre_rst_count", 40'(count_out), 40'h1);
    #2 rst_n_in = 1'b0;
    #1;
    chk("async_rst_mem_req", 40'(mem_req_out), 40'h0);
    chk("async_rst_count", 40'(count_out), 40'h0);
    chk("async_rst_valid", 40'(instr_valid_out), 40'h0);
    @(negedge clk_in);
    #2 rst_n_in = 1'b1;
    @(negedge clk_in);
    sb.delete();
    m_pend = 1'b0;
    m_drop = 1'b0;
    run_vec(mk(1'b0, 8'h00, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0), 1'b0);
    run_vec(mk(1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning instruction queue entries (power of two, 2..8).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning instruction word width.
REQ-003 The block SHALL have port clk_in, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n_in, input, 1, meaning reset, asynchronous and active-low.
REQ-005 The block SHALL have port pc_in, input, 8, meaning fetch address from the program counter.
REQ-006 The block SHALL have port pc_valid_in, input, 1, meaning pc_in is a valid fetch request.
REQ-007 The block SHALL have port pc_ready_out, output, 1, meaning the block accepts pc_in this cycle.
REQ-008 The block SHALL have port flush_in, input, 1, meaning a jump was taken; discard all queued and in-flight fetches.
REQ-009 The block SHALL have port mem_req_out, output, 1, meaning an instruction memory read is outstanding.
REQ-010 The block SHALL have port mem_addr_out, output, 8, meaning the instruction memory read address.
REQ-011 The block SHALL have port mem_ack_in, input, 1, meaning mem_data_in is valid for the outstanding read.
REQ-012 The block SHALL have port mem_data_in, input, DATA_W, meaning the instruction word returned by memory.
REQ-013 The block SHALL have port instr_out, output, DATA_W, meaning the instruction at the queue head.
REQ-014 The block SHALL have port instr_addr_out, output, 8, meaning the fetch address of instr_out.
REQ-015 The block SHALL have port instr_valid_out, output, 1, meaning the queue is non-empty.
REQ-016 The block SHALL have port instr_ready_in, input, 1, meaning the decoder consumes the head entry this cycle.
REQ-017 The block SHALL have port count_out, output, 4, meaning the number of valid queue entries.

Function
REQ-018 The FSM SHALL have states IDLE (no read outstanding), WAIT (read outstanding), and DROP (read outstanding, result to be discarded).
REQ-019 pc_ready_out SHALL be 1 only when state is IDLE, count_out < DEPTH and flush_in=0 (combinational).
REQ-020 A fetch SHALL be accepted when pc_valid_in and pc_ready_out are both 1; on the next edge mem_addr_out <= pc_in, mem_req_out <= 1, and the state goes to WAIT.
REQ-021 mem_req_out and mem_addr_out SHALL hold stable in WAIT/DROP until the cycle mem_ack_in=1; at most one read is outstanding.
REQ-022 mem_ack_in SHALL be ignored in IDLE.
REQ-023 On mem_ack_in in WAIT with flush_in=0, the block SHALL write {mem_addr_out, mem_data_in} at the tail, drop mem_req_out, and go to IDLE; instr_valid_out rises on the following cycle (1-cycle ack-to-valid latency).
REQ-024 On mem_ack_in in DROP, the block SHALL discard the data, drop mem_req_out, and go to IDLE.
REQ-025 A pop SHALL occur when instr_valid_out and instr_ready_in are both 1; the head advances on that edge.
REQ-026 A simultaneous push and pop SHALL leave count_out unchanged and keep FIFO order.
REQ-027 A push SHALL never overflow the queue, because acceptance requires count_out < DEPTH and a single outstanding read.
REQ-028 Read/write pointers SHALL wrap modulo DEPTH; count_out SHALL range 0..DEPTH.
REQ-029 flush_in=1 SHALL on the next edge empty the queue (count_out=0, pointers reset, instr_valid_out=0) and take priority over a pop in the same cycle.
REQ-030 flush_in=1 in WAIT without mem_ack_in SHALL move the FSM to DROP.
REQ-031 flush_in=1 in WAIT with mem_ack_in in the same cycle SHALL discard that data and move the FSM to IDLE.
REQ-032 flush_in=1 in IDLE SHALL leave the FSM in IDLE; no fetch is accepted in the flush cycle.
REQ-033 flush_in=1 in DROP SHALL keep the FSM in DROP, or move it to IDLE on mem_ack_in.
REQ-034 instr_out and instr_addr_out SHALL be don't-care while instr_valid_out=0.

Reset
REQ-035 While rst_n_in=0, the block SHALL immediately set state=IDLE, mem_req_out=0, mem_addr_out=0, count_out=0, pointers=0, instr_valid_out=0, instr_out=0 and instr_addr_out=0.
REQ-036 Reset mid-read SHALL abandon the outstanding read; a mem_ack_in arriving after reset release, with state IDLE, SHALL be ignored.

Verification
REQ-037 Basic fetch: pc_in=0x10 accepted at cycle 0, mem_ack_in at cycle 3 with data 0xE3A01005 -> mem_req_out=1 on cycles 1-3, instr_valid_out=1 at cycle 4 with instr_out=0xE3A01005 and instr_addr_out=0x10.
REQ-038 Fill/full: addresses 0x00..0x03 with 1-cycle acks and instr_ready_in=0 -> count_out=4, pc_ready_out=0; one pop -> count_out=3, pc_ready_out=1; pops return entries in order 0x00..0x03.
REQ-039 Flush with read pending: 2 entries queued, read of 0x05 outstanding, flush_in pulsed -> count_out=0 next cycle, state DROP; the later ack is discarded, count_out stays 0, and pc_ready_out returns to 1.
REQ-040 Flush coincident with ack: flush_in and mem_ack_in in the same cycle -> nothing written, state IDLE, count_out=0.
REQ-041 Push+pop: count_out=2, ack and pop in the same cycle -> count_out=2 and head = the former second entry; pointer wrap exercised over 10 or more entries.
REQ-042 Async reset: rst_n_in low mid-WAIT, not aligned to clk_in -> mem_req_out=0 and count_out=0 immediately; a stray ack after release is ignored.
